// File: rtl/trunc_mult_pkg.sv
// Shared definitions for the truncated-multiplier datapath and its accumulator back-end.
//   DATA_W_DEF  : default product width (upper byte of the 8x8 product)
//   ACC_W_DEF   : default accumulator width
//   acc_state_e : accumulator FSM states
//   sat_add     : saturating add at the default widths, returns {sat, sum}
package trunc_mult_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  function automatic logic [ACC_W_DEF:0] sat_add(input logic [ACC_W_DEF-1:0]  acc,
                                                input logic [DATA_W_DEF-1:0] prod);
    logic [ACC_W_DEF:0] full;
    full = {1'b0, acc} + {{(ACC_W_DEF+1-DATA_W_DEF){1'b0}}, prod};
    if (full[ACC_W_DEF]) begin
      sat_add = {1'b1, {ACC_W_DEF{1'b1}}};
    end else begin
      sat_add = {1'b0, full[ACC_W_DEF-1:0]};
    end
  endfunction

endpackage

// File: rtl/trunc_sat_adder.sv
// Combinational saturating adder: acc + zero-extended prod, clamped at all-ones.
//   acc_i  : running sum
//   prod_i : unsigned product term
//   sum_o  : clamped sum
//   ovf_o  : high when the true sum did not fit in ACC_W bits
module trunc_sat_adder
  import trunc_mult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W:0] full;

  // One extra bit of headroom catches the carry-out that signals overflow.
  assign full  = {1'b0, acc_i} + {{(ACC_W+1-DATA_W){1'b0}}, prod_i};
  assign ovf_o = full[ACC_W];
  assign sum_o = ovf_o ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/trunc_prod_accumulator.sv
// Frame accumulator for truncated products with a single registered result slot.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : product beat handshake (in_prod, in_last)
//   out_valid/out_ready          : frame result handshake
//   out_acc, out_count, out_sat  : saturated frame sum, term count, saturation flag
//
//   state | meaning
//   ACCUM | collecting terms, result slot empty
//   HOLD  | result presented, waiting for out_ready
module trunc_prod_accumulator
  import trunc_mult_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  if (ACC_W < DATA_W) begin : g_width_check
    $error("ACC_W must be >= DATA_W");
  end

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;

  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_next;
  logic             take;
  logic             close;

  trunc_sat_adder #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i  (acc_q),
    .prod_i (in_prod),
    .sum_o  (sum),
    .ovf_o  (ovf)
  );

  // A draining result frees the slot in the same cycle, so a new beat may enter.
  assign in_ready = (state_q == ACCUM) || out_ready;
  assign take     = in_valid && in_ready;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign sat_next = sat_q | ovf;
  assign close    = take && (in_last || (cnt_inc == CNT_W'(MAX_LEN)));

  // acc/cnt/sat are already cleared on close, so a beat taken in HOLD
  // naturally starts the next frame from zero.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    if (take) begin
      if (close) begin
        out_acc_d   = sum;
        out_count_d = cnt_inc;
        out_sat_d   = sat_next;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        sat_d       = 1'b0;
        state_d     = HOLD;
      end else begin
        acc_d       = sum;
        cnt_d       = cnt_inc;
        sat_d       = sat_next;
        out_valid_d = 1'b0;
        state_d     = ACCUM;
      end
    end else if ((state_q == HOLD) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_trunc_prod_accumulator.sv
// Bench: two accumulators (ACC_W=12 and ACC_W=9) share one stimulus stream and
// are compared each cycle against a frame-level reference model.
module tb_trunc_prod_accumulator;

  localparam int MAX_LEN = 16;
  localparam int LIM12   = 4095;
  localparam int LIM9    = 511;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready12, in_ready9;
  logic        out_valid12, out_valid9;
  logic [11:0] out_acc12;
  logic [8:0]  out_acc9;
  logic [4:0]  out_count12, out_count9;
  logic        out_sat12, out_sat9;

  int checks = 0;
  int errors = 0;

  // reference model: current frame terms and the result slot
  int   frame[$];
  bit   slot_full;
  int   exp_acc12, exp_acc9, exp_cnt;
  bit   exp_sat12, exp_sat9;

  always #5 clk = ~clk;

  trunc_prod_accumulator #(.ACC_W(12)) dut12 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready12),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid12),
    .out_ready (out_ready),
    .out_acc   (out_acc12),
    .out_count (out_count12),
    .out_sat   (out_sat12)
  );

  trunc_prod_accumulator #(.ACC_W(9)) dut9 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready9),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid9),
    .out_ready (out_ready),
    .out_acc   (out_acc9),
    .out_count (out_count9),
    .out_sat   (out_sat9)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    slot_full = 0;
    frame.delete();
    exp_acc12 = 0;
    exp_acc9  = 0;
    exp_cnt   = 0;
    exp_sat12 = 0;
    exp_sat9  = 0;
  endtask

  task automatic close_frame();
    int total;
    total = 0;
    foreach (frame[i]) total += frame[i];
    exp_acc12 = (total > LIM12) ? LIM12 : total;
    exp_sat12 = (total > LIM12);
    exp_acc9  = (total > LIM9) ? LIM9 : total;
    exp_sat9  = (total > LIM9);
    exp_cnt   = frame.size();
    slot_full = 1;
    frame.delete();
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check outputs.
  task automatic cycle(input logic v, input logic [7:0] p, input logic l,
                       input logic ordy, input logic r);
    bit exp_rdy;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = ordy;
    #1;
    if (r) begin
      model_reset();
    end else begin
      exp_rdy = !slot_full || ordy;
      check_eq("in_ready12", in_ready12, exp_rdy);
      check_eq("in_ready9", in_ready9, exp_rdy);
      if (slot_full && ordy) slot_full = 0;
      if (v && exp_rdy) begin
        frame.push_back(int'(p));
        if (l || frame.size() == MAX_LEN) close_frame();
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_valid12", out_valid12, slot_full);
    check_eq("out_valid9", out_valid9, slot_full);
    check_eq("out_acc12", out_acc12, exp_acc12);
    check_eq("out_acc9", out_acc9, exp_acc9);
    check_eq("out_count12", out_count12, exp_cnt);
    check_eq("out_count9", out_count9, exp_cnt);
    check_eq("out_sat12", out_sat12, exp_sat12);
    check_eq("out_sat9", out_sat9, exp_sat9);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_prod   = 8'hAA;
    in_last   = 1'b1;
    out_ready = 1'b1;
    model_reset();

    // reset with beats presented: nothing counted
    cycle(1, 8'hAA, 1, 1, 1);
    cycle(1, 8'hAA, 1, 1, 1);
    cycle(0, 8'h00, 0, 1, 0);

    // basic three-beat frame
    cycle(1, 8'h30, 0, 1, 0);
    cycle(1, 8'h48, 0, 1, 0);
    cycle(1, 8'h10, 1, 1, 0);

    // backpressure: offered beats must not be taken
    for (int i = 0; i < 5; i++) cycle(1, 8'h77, 1, 0, 0);
    cycle(1, 8'h05, 1, 1, 0);
    cycle(0, 8'h00, 0, 1, 0);

    // auto-close at MAX_LEN, 17th beat opens a new frame
    for (int i = 0; i < 16; i++) cycle(1, 8'h01, 0, 1, 0);
    cycle(1, 8'h01, 0, 1, 0);
    cycle(1, 8'h02, 1, 1, 0);
    cycle(0, 8'h00, 0, 1, 0);

    // saturation on the 9-bit instance, then a clean frame
    cycle(1, 8'hFF, 0, 1, 0);
    cycle(1, 8'hFF, 0, 1, 0);
    cycle(1, 8'hFF, 1, 1, 0);
    cycle(1, 8'h02, 1, 1, 0);
    cycle(0, 8'h00, 0, 1, 0);

    // reset mid-frame discards the partial sum
    cycle(1, 8'h20, 0, 1, 0);
    cycle(1, 8'h20, 0, 1, 0);
    cycle(1, 8'h55, 1, 1, 1);
    cycle(1, 8'h07, 1, 1, 0);
    cycle(0, 8'h00, 0, 1, 0);

    // reset while a result is pending drops it
    cycle(1, 8'h09, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0);

    // randomized traffic, heavy products to exercise saturation
    for (int i = 0; i < 800; i++) begin
      logic       v, l, ordy, r;
      logic [7:0] p;
      v    = ($urandom_range(0, 99) < 75);
      p    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(200, 255)) : 8'($urandom);
      l    = ($urandom_range(0, 99) < 20);
      ordy = ($urandom_range(0, 99) < 60);
      r    = ($urandom_range(0, 199) == 0);
      cycle(v, p, l, ordy, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
